axi_lite_write_master: RTL and testbench

AXI4-Lite write initiator that drives the write address, write data and write response channels of a memory-mapped slave, such as the team's AXI-Lite slave memory. A local command port accepts one write (address, data, strobe) at a time. The block issues AW and W concurrently and holds each VALID until its handshake completes. It then collects the B response, reports it with a one-cycle done pulse, and aborts with a timeout status if the slave stalls.

---
 rtl/axi_lite_write_master.sv | 140 ++++++++++++++
 tb/tb_axi_lite_write_master.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/axi_lite_write_master.sv
// axi_lite_write_master: single-outstanding AXI4-Lite write initiator with B-response reporting and timeout abort
module axi_lite_write_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                m_axi_aclk,
   input  logic                m_axi_aresetn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_data,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                done,
   output logic [1:0]          done_resp,
   output logic                timeout_err,
   output logic [7:0]          err_count,
   output logic                m_axi_awvalid,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   input  logic                m_axi_awready,
   output logic                m_axi_wvalid,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   input  logic                m_axi_wready,
   input  logic                m_axi_bvalid,
   input  logic [1:0]          m_axi_bresp,
   output logic                m_axi_bready
);
   typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;
   localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);
   state_t                state_q, state_d;
   logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                  done_q, done_d, timeout_err_q, timeout_err_d;
   logic [1:0]            done_resp_q, done_resp_d;
   logic [7:0]            err_count_q, err_count_d;
   logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
   logic [15:0]           timer_q, timer_d;
   logic                  b_hs, tmo, err_inc;
   always_comb begin
      state_d       = state_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      done_d        = 1'b0;
      timeout_err_d = 1'b0;
      done_resp_d   = done_resp_q;
      awaddr_d      = awaddr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      timer_d       = timer_q;
      err_inc       = 1'b0;
      b_hs          = (state_q == WAIT_B) && bready_q && m_axi_bvalid;
      tmo           = (state_q != IDLE) && (timer_q == TMAX) && !b_hs;
      case (state_q)
         IDLE: if (cmd_valid) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_data;
            wstrb_d   = cmd_strb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            timer_d   = '0;
            state_d   = SEND;
         end
         SEND: begin
            // each VALID retires on its own handshake; a VALID already low counts as done
            awvalid_d = awvalid_q && !m_axi_awready;
            wvalid_d  = wvalid_q && !m_axi_wready;
            timer_d   = timer_q + 16'd1;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = WAIT_B;
               bready_d = 1'b1;
            end
         end
         WAIT_B: begin
            timer_d = timer_q + 16'd1;
            if (b_hs) begin
               done_d      = 1'b1;
               done_resp_d = m_axi_bresp;
               bready_d    = 1'b0;
               err_inc     = m_axi_bresp != 2'b00;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (tmo) begin
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         bready_d      = 1'b0;
         done_d        = 1'b1;
         done_resp_d   = 2'b11;
         timeout_err_d = 1'b1;
         err_inc       = 1'b1;
         state_d       = IDLE;
      end
      err_count_d = (err_inc && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
   end
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         state_q       <= IDLE;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         done_resp_q   <= 2'b00;
         err_count_q   <= '0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         timer_q       <= '0;
      end else begin
         state_q       <= state_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
         done_resp_q   <= done_resp_d;
         err_count_q   <= err_count_d;
         awaddr_q      <= awaddr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         timer_q       <= timer_d;
      end
   end
   assign cmd_ready     = state_q == IDLE;
   assign done          = done_q;
   assign done_resp     = done_resp_q;
   assign timeout_err   = timeout_err_q;
   assign err_count     = err_count_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_bready  = bready_q;
endmodule

// File: tb/tb_axi_lite_write_master.sv
// tb_axi_lite_write_master: directed checks of the AXI-Lite write master against a scripted slave
module tb_axi_lite_write_master;
   logic        clk = 0, rst_n = 0;
   logic        cmd_valid = 0, cmd_ready;
   logic [31:0] cmd_addr = 0, cmd_data = 0;
   logic [3:0]  cmd_strb = 0;
   logic        done, timeout_err;
   logic [1:0]  done_resp;
   logic [7:0]  err_count;
   logic        awvalid, wvalid, bready;
   logic [31:0] awaddr, wdata;
   logic [3:0]  wstrb;
   logic        awready = 0, wready = 0, bvalid_s = 0, bv_force = 0;
   logic [1:0]  bresp = 0;
   int          aw_dly = 0, w_dly = 0, b_dly = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   int          aw_hs = 0, w_hs = 0, cyc = 0, aw_first = 0;
   logic        b_en = 1;
   logic [1:0]  b_code = 0;
   int          n_cmp = 0, n_bad = 0;
   axi_lite_write_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .cmd_strb(cmd_strb),
      .done(done), .done_resp(done_resp), .timeout_err(timeout_err), .err_count(err_count),
      .m_axi_awvalid(awvalid), .m_axi_awaddr(awaddr), .m_axi_awready(awready),
      .m_axi_wvalid(wvalid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wready(wready),
      .m_axi_bvalid(bvalid_s | bv_force), .m_axi_bresp(bresp), .m_axi_bready(bready)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   // slave decides its READY/VALID on the falling edge from the outputs the master registered
   always @(negedge clk) begin
      if (awvalid && aw_cnt == 0) aw_first = cyc;
      awready = awvalid && aw_cnt == aw_dly;
      if (awready) aw_hs++;
      aw_cnt = awvalid ? aw_cnt + 1 : 0;
      wready = wvalid && w_cnt == w_dly;
      if (wready) w_hs++;
      w_cnt = wvalid ? w_cnt + 1 : 0;
      bvalid_s = bready && b_en && b_cnt == b_dly;
      bresp = bvalid_s ? b_code : 2'b00;
      b_cnt = bready ? b_cnt + 1 : 0;
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      cmd_valid = 1; cmd_addr = a; cmd_data = d; cmd_strb = s;
      @(negedge clk);
      cmd_valid = 0;
   endtask
   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) check({tag, "_done_seen"}, 0, 1);
   endtask
   initial begin
      int cnt;
      repeat (3) @(negedge clk);
      check("rst_awvalid", awvalid, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_err_count", err_count, 0);
      check("rst_done_resp", {done, done_resp}, 0);
      rst_n = 1;
      // basic write with 1-cycle READY latency
      aw_dly = 1; w_dly = 1; b_dly = 1; b_code = 0;
      issue(32'h4, 32'hDEADBEEF, 4'hF);
      check("t1_valids", {awvalid, wvalid, cmd_ready}, 3'b110);
      check("t1_payload", {awaddr, wdata}, {32'h4, 32'hDEADBEEF});
      check("t1_strb", wstrb, 4'hF);
      wait_done("t1");
      check("t1_resp", {done_resp, timeout_err}, 3'b000);
      check("t1_cmd_ready_done", cmd_ready, 1);
      check("t1_hs", {aw_hs[7:0], w_hs[7:0]}, 16'h0101);
      check("t1_bready_low", bready, 0);
      check("t1_err", err_count, 0);
      @(negedge clk);
      check("t1_done_pulse", done, 0);
      // W handshake late; ignore new cmd while busy
      aw_hs = 0; w_hs = 0; w_dly = 6;
      issue(32'h8, 32'h12345678, 4'h3);
      @(negedge clk);
      cmd_valid = 1; cmd_addr = 32'hBAD0; cmd_data = 32'hBAD1;
      repeat (2) @(negedge clk);
      check("t2_valids", {awvalid, wvalid}, 2'b01);
      check("t2_wdata_stable", {awaddr, wdata}, {32'h8, 32'h12345678});
      check("t2_wstrb_stable", wstrb, 4'h3);
      cmd_valid = 0;
      wait_done("t2");
      check("t2_resp", done_resp, 0);
      check("t2_hs", {aw_hs[7:0], w_hs[7:0]}, 16'h0101);
      // SLVERR delivered as a single-cycle bvalid
      w_dly = 1; b_dly = 0; b_code = 2'b10;
      issue(32'h20, 32'h55, 4'h1);
      wait_done("t3");
      check("t3_resp", done_resp, 2'b10);
      check("t3_err", err_count, 1);
      // no B response: timeout after 16 cycles
      aw_dly = 0; w_dly = 0; b_en = 0;
      issue(32'h30, 32'h66, 4'hF);
      wait_done("t4");
      check("t4_latency", cyc - aw_first, 16);
      check("t4_resp", {done_resp, timeout_err}, 3'b111);
      check("t4_quiet", {awvalid, wvalid, bready}, 0);
      check("t4_err", err_count, 2);
      b_en = 1; b_code = 0;
      issue(32'h34, 32'h77, 4'hF);
      wait_done("t4b");
      check("t4b_resp", {done_resp, timeout_err}, 3'b000);
      check("t4b_err", err_count, 2);
      // async reset while waiting for B
      b_en = 0;
      issue(32'h40, 32'h88, 4'hF);
      cnt = 0;
      for (int i = 0; i < 20 && !bready; i++) @(negedge clk);
      check("t5_in_wait_b", bready, 1);
      rst_n = 0;
      #1;
      check("t5_rst_outs", {awvalid, wvalid, bready, done, timeout_err, done_resp}, 0);
      check("t5_rst_regs", {err_count, awaddr, wdata, wstrb}, 0);
      check("t5_rst_ready", cmd_ready, 1);
      @(negedge clk);
      rst_n = 1;
      bv_force = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 2) bv_force = 0;
         if (done) cnt++;
      end
      check("t5_no_done", cnt, 0);
      // saturation of error counter
      b_en = 1; b_code = 2'b11;
      for (int i = 0; i < 300; i++) begin
         issue(i, i, 4'hF);
         wait_done("t6");
         if (i == 253) check("t6_err_254", err_count, 254);
         if (i == 254) check("t6_err_255", err_count, 255);
      end
      check("t6_err_sat", err_count, 255);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
